// File: rtl/mem_responder_if.sv
// Cache-to-memory request/response bundle for mem_responder.
// The cache side uses the master modport, the responder uses slave.
// Optional macro MEM_RESP_ALIGN_CHECK_EN adds the mem_error response line.
interface mem_responder_if;
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic              mem_write_en;
  logic [0:3][7:0]   mem_data_in;
  logic [0:3][7:0]   mem_data_out;
  logic              mem_ready;
  logic              mem_busy;
`ifdef MEM_RESP_ALIGN_CHECK_EN
  logic              mem_error;
`endif

  modport master (
    output mem_req, mem_addr, mem_write_en, mem_data_in,
    input  mem_data_out, mem_ready, mem_busy
`ifdef MEM_RESP_ALIGN_CHECK_EN
    , input mem_error
`endif
  );

  modport slave (
    input  mem_req, mem_addr, mem_write_en, mem_data_in,
    output mem_data_out, mem_ready, mem_busy
`ifdef MEM_RESP_ALIGN_CHECK_EN
    , output mem_error
`endif
  );
endinterface

// File: rtl/mem_responder.sv
// Main-memory model behind the data cache: one word request at a time,
// serviced from a big-endian byte array after LATENCY cycles, completion
// signalled by a single-cycle mem_ready pulse.
// Optional macro MEM_RESP_ALIGN_CHECK_EN: misaligned requests complete with
// mem_error instead of touching the array; without it the low address bits
// are simply dropped.
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BYTES = 4 * DEPTH;
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                  state;
  logic [7:0]              count;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [0:3][7:0]         wdata_q;
  logic [0:3][7:0]         data_out_q;
  logic                    ready_q;
  logic                    busy_q;
`ifdef MEM_RESP_ALIGN_CHECK_EN
  logic                    misaligned_q;
  logic                    error_q;
`endif

  // Byte 4*w+0 holds the most significant byte of word w.
  logic [7:0]              mem_bytes [BYTES];
  logic [0:3][7:0]         rd_word;
  logic                    done;
  logic                    commit;
  logic                    unused_addr_bits;

  // Address bits above the word index (and, without the check, the byte
  // offset) are deliberately discarded so accesses wrap.
  assign unused_addr_bits = ^bus.mem_addr;

  assign done = (state == WAIT) && (count == 8'd0);

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign commit = done && write_q && !reset && !misaligned_q;
`else
  assign commit = done && write_q && !reset;
`endif

  assign bus.mem_data_out = data_out_q;
  assign bus.mem_ready    = ready_q;
  assign bus.mem_busy     = busy_q;
`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign bus.mem_error    = error_q;
`endif

  // Gather the four bytes of the latched word for a read completion.
  always_comb begin
    rd_word = '0;
    for (int b = 0; b < 4; b++) begin
      rd_word[b] = mem_bytes[{addr_q, b[1:0]}];
    end
  end

  // Array write happens only on the completion edge, never on an aborted one.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        mem_bytes[{addr_q, b[1:0]}] <= wdata_q[b];
      end
    end
  end

  // Request FSM: latch in IDLE, count down in WAIT, complete with a pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= 8'd0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      data_out_q   <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
`ifdef MEM_RESP_ALIGN_CHECK_EN
      misaligned_q <= 1'b0;
      error_q      <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef MEM_RESP_ALIGN_CHECK_EN
      error_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.mem_req) begin
            addr_q       <= bus.mem_addr[ADDR_WIDTH+1:2];
            write_q      <= bus.mem_write_en;
            wdata_q      <= bus.mem_data_in;
`ifdef MEM_RESP_ALIGN_CHECK_EN
            misaligned_q <= |bus.mem_addr[1:0];
`endif
            count        <= LAT_M1;
            busy_q       <= 1'b1;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (count != 8'd0) begin
            count <= count - 8'd1;
          end else begin
`ifdef MEM_RESP_ALIGN_CHECK_EN
            if (misaligned_q) begin
              data_out_q <= '0;
              error_q    <= 1'b1;
            end else
`endif
            if (write_q) begin
              data_out_q <= wdata_q;
            end else begin
              data_out_q <= rd_word;
            end
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: a LATENCY=4 instance for
// the main scenarios and a LATENCY=1 instance for the minimum-latency case.
module tb_mem_responder;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mem_responder_if bus();
  mem_responder_if bus1();

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on the LATENCY=4 port and wait (bounded) for ready.
  // Returns with the ready cycle being sampled; lat is -1 on timeout.
  task automatic do_request(input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat);
    bus.mem_req      = 1'b1;
    bus.mem_addr     = addr;
    bus.mem_write_en = we;
    bus.mem_data_in  = wdata;
    tick();
    bus.mem_req = 1'b0;
    lat = 0;
    while (bus.mem_ready !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    if (bus.mem_ready !== 1'b1) lat = -1;
    rdata = bus.mem_data_out;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.mem_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.mem_ready);
    end
    checks++;
    if (bus.mem_busy !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.mem_busy);
    end
    checks++;
    if (bus.mem_data_out !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_data: got %h expected 00000000", bus.mem_data_out);
    end
    checks++;
    if (bus1.mem_busy !== 1'b0 || bus1.mem_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_lat1: got busy %b ready %b expected 0 0", bus1.mem_busy, bus1.mem_ready);
    end
`ifdef MEM_RESP_ALIGN_CHECK_EN
    checks++;
    if (bus.mem_error !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_error: got %b expected 0", bus.mem_error);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_read_latency();
    logic [31:0] rd;
    int lat;
    int busy_count;
    int ready_count;
    int ready_k;
    logic [31:0] ready_data;
    do_request(32'h0, 1'b1, 32'h11223344, rd, lat);
    checks++;
    if (lat != 4) begin
      failures++; $display("[TB] FAIL preload_latency: got %0d expected 4", lat);
    end
    checks++;
    if (rd !== 32'h11223344) begin
      failures++; $display("[TB] FAIL preload_echo: got %h expected 11223344", rd);
    end
    bus.mem_req      = 1'b1;
    bus.mem_addr     = 32'h0;
    bus.mem_write_en = 1'b0;
    tick();
    bus.mem_req = 1'b0;
    busy_count  = 0;
    ready_count = 0;
    ready_k     = -1;
    ready_data  = '0;
    for (int k = 0; k < 8; k++) begin
      if (bus.mem_busy === 1'b1) busy_count++;
      if (bus.mem_ready === 1'b1) begin
        ready_count++;
        ready_k    = k;
        ready_data = bus.mem_data_out;
      end
      tick();
    end
    checks++;
    if (busy_count != 4) begin
      failures++; $display("[TB] FAIL read_busy_cycles: got %0d expected 4", busy_count);
    end
    checks++;
    if (ready_count != 1) begin
      failures++; $display("[TB] FAIL read_ready_pulses: got %0d expected 1", ready_count);
    end
    checks++;
    if (ready_k != 4) begin
      failures++; $display("[TB] FAIL read_ready_time: got E0+%0d expected E0+4", ready_k);
    end
    checks++;
    if (ready_data !== 32'h11223344) begin
      failures++; $display("[TB] FAIL read_data: got %h expected 11223344", ready_data);
    end
    checks++;
    if (bus.mem_data_out !== 32'h11223344) begin
      failures++; $display("[TB] FAIL read_data_hold: got %h expected 11223344", bus.mem_data_out);
    end
  endtask

  task automatic test_back_to_back();
    int ready_count;
    int first_k;
    int second_k;
    logic [31:0] first_data;
    logic [31:0] second_data;
    bus.mem_req      = 1'b1;
    bus.mem_addr     = 32'h10;
    bus.mem_write_en = 1'b1;
    bus.mem_data_in  = 32'hDEADBEEF;
    tick();
    bus.mem_write_en = 1'b0;
    bus.mem_data_in  = 32'h0;
    ready_count = 0;
    first_k     = -1;
    second_k    = -1;
    first_data  = '0;
    second_data = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.mem_ready === 1'b1) begin
        ready_count++;
        if (ready_count == 1) begin
          first_k = k; first_data = bus.mem_data_out;
        end else begin
          second_k = k; second_data = bus.mem_data_out;
        end
      end
      if (ready_count == 2) break;
    end
    bus.mem_req = 1'b0;
    checks++;
    if (first_k != 4 || first_data !== 32'hDEADBEEF) begin
      failures++; $display("[TB] FAIL b2b_write: got E0+%0d data %h expected E0+4 data deadbeef", first_k, first_data);
    end
    checks++;
    if (second_k != 9) begin
      failures++; $display("[TB] FAIL b2b_read_time: got E0+%0d expected E0+9", second_k);
    end
    checks++;
    if (second_data !== 32'hDEADBEEF) begin
      failures++; $display("[TB] FAIL b2b_read_data: got %h expected deadbeef", second_data);
    end
    checks++;
    if (bus.mem_data_out[0] !== 8'hDE) begin
      failures++; $display("[TB] FAIL b2b_byte0: got %h expected de", bus.mem_data_out[0]);
    end
    tick();
    checks++;
    if (bus.mem_busy !== 1'b0) begin
      failures++; $display("[TB] FAIL b2b_idle_after: got busy %b expected 0", bus.mem_busy);
    end
  endtask

  task automatic test_ignore_busy();
    int ready_count;
    int ready_k;
    int busy_at5;
    bus.mem_req      = 1'b1;
    bus.mem_addr     = 32'h10;
    bus.mem_write_en = 1'b0;
    tick();
    bus.mem_req = 1'b0;
    ready_count = 0;
    ready_k     = -1;
    busy_at5    = -1;
    for (int k = 1; k <= 12; k++) begin
      bus.mem_req = (k == 2);
      tick();
      bus.mem_req = 1'b0;
      if (bus.mem_ready === 1'b1) begin
        ready_count++;
        ready_k = k;
      end
      if (k == 5) busy_at5 = int'(bus.mem_busy);
    end
    checks++;
    if (ready_count != 1) begin
      failures++; $display("[TB] FAIL busy_req_pulses: got %0d expected 1", ready_count);
    end
    checks++;
    if (ready_k != 4) begin
      failures++; $display("[TB] FAIL busy_req_time: got E0+%0d expected E0+4", ready_k);
    end
    checks++;
    if (busy_at5 != 0) begin
      failures++; $display("[TB] FAIL busy_req_queued: got busy %0d expected 0", busy_at5);
    end
    checks++;
    if (bus.mem_data_out !== 32'hDEADBEEF) begin
      failures++; $display("[TB] FAIL busy_req_data: got %h expected deadbeef", bus.mem_data_out);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    int lat;
    int ready_count;
    do_request(32'h8, 1'b1, 32'h01020304, rd, lat);
    tick();
    bus.mem_req      = 1'b1;
    bus.mem_addr     = 32'h8;
    bus.mem_write_en = 1'b1;
    bus.mem_data_in  = 32'hAABBCCDD;
    tick();
    bus.mem_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.mem_busy !== 1'b0 || bus.mem_ready !== 1'b0 || bus.mem_data_out !== 32'h0) begin
      failures++; $display("[TB] FAIL abort_outputs: got busy %b ready %b data %h expected 0 0 00000000",
                           bus.mem_busy, bus.mem_ready, bus.mem_data_out);
    end
    ready_count = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.mem_ready === 1'b1) ready_count++;
    end
    checks++;
    if (ready_count != 0) begin
      failures++; $display("[TB] FAIL abort_ready: got %0d pulses expected 0", ready_count);
    end
    do_request(32'h8, 1'b0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h01020304 || lat != 4) begin
      failures++; $display("[TB] FAIL abort_old_data: got %h lat %0d expected 01020304 lat 4", rd, lat);
    end
    tick();
    bus.mem_req      = 1'b1;
    bus.mem_addr     = 32'h8;
    bus.mem_write_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mem_req = 1'b0;
    ready_count = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.mem_busy === 1'b1 || bus.mem_ready === 1'b1) ready_count++;
      tick();
    end
    checks++;
    if (ready_count != 0) begin
      failures++; $display("[TB] FAIL reset_req_dropped: got %0d active cycles expected 0", ready_count);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    int lat;
    do_request(32'h1004, 1'b1, 32'h12345678, rd, lat);
    tick();
    do_request(32'h4, 1'b0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h12345678) begin
      failures++; $display("[TB] FAIL wrap_read: got %h expected 12345678", rd);
    end
    tick();
    do_request(32'h1000, 1'b0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h11223344) begin
      failures++; $display("[TB] FAIL wrap_index0: got %h expected 11223344", rd);
    end
    tick();
  endtask

  task automatic test_align();
    logic [31:0] rd;
    int lat;
    do_request(32'h4, 1'b1, 32'h55667788, rd, lat);
    tick();
`ifdef MEM_RESP_ALIGN_CHECK_EN
    do_request(32'h6, 1'b1, 32'h99999999, rd, lat);
    checks++;
    if (lat != 4 || bus.mem_error !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("[TB] FAIL align_error: got lat %0d error %b data %h expected 4 1 00000000",
                           lat, bus.mem_error, rd);
    end
    tick();
    checks++;
    if (bus.mem_error !== 1'b0) begin
      failures++; $display("[TB] FAIL align_error_pulse: got %b expected 0", bus.mem_error);
    end
    do_request(32'h4, 1'b0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h55667788 || bus.mem_error !== 1'b0) begin
      failures++; $display("[TB] FAIL align_unchanged: got %h error %b expected 55667788 0", rd, bus.mem_error);
    end
`else
    do_request(32'h6, 1'b1, 32'h99999999, rd, lat);
    tick();
    do_request(32'h4, 1'b0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h99999999) begin
      failures++; $display("[TB] FAIL align_truncate: got %h expected 99999999", rd);
    end
`endif
    tick();
  endtask

  task automatic test_latency_one();
    bus1.mem_req      = 1'b1;
    bus1.mem_addr     = 32'h20;
    bus1.mem_write_en = 1'b1;
    bus1.mem_data_in  = 32'hCAFEF00D;
    tick();
    bus1.mem_req = 1'b0;
    checks++;
    if (bus1.mem_busy !== 1'b1 || bus1.mem_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL lat1_busy: got busy %b ready %b expected 1 0", bus1.mem_busy, bus1.mem_ready);
    end
    tick();
    checks++;
    if (bus1.mem_ready !== 1'b1 || bus1.mem_busy !== 1'b0 || bus1.mem_data_out !== 32'hCAFEF00D) begin
      failures++; $display("[TB] FAIL lat1_done: got ready %b busy %b data %h expected 1 0 cafef00d",
                           bus1.mem_ready, bus1.mem_busy, bus1.mem_data_out);
    end
    bus1.mem_req      = 1'b1;
    bus1.mem_write_en = 1'b0;
    bus1.mem_data_in  = 32'h0;
    tick();
    bus1.mem_req = 1'b0;
    checks++;
    if (bus1.mem_ready !== 1'b0 || bus1.mem_busy !== 1'b1) begin
      failures++; $display("[TB] FAIL lat1_reaccept: got ready %b busy %b expected 0 1", bus1.mem_ready, bus1.mem_busy);
    end
    tick();
    checks++;
    if (bus1.mem_ready !== 1'b1 || bus1.mem_data_out !== 32'hCAFEF00D) begin
      failures++; $display("[TB] FAIL lat1_read: got ready %b data %h expected 1 cafef00d",
                           bus1.mem_ready, bus1.mem_data_out);
    end
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.mem_req       = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_write_en  = 1'b0;
    bus.mem_data_in   = '0;
    bus1.mem_req      = 1'b0;
    bus1.mem_addr     = '0;
    bus1.mem_write_en = 1'b0;
    bus1.mem_data_in  = '0;
    $display("[TB] starting mem_responder bench");
    test_reset();
    test_read_latency();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    test_wrap();
    test_align();
    test_latency_one();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
